// File: rtl/fetch_tlb_pkg.sv
// Shared types and default configuration for the pipelined fetch TLB.
// Provides the entry record, default widths and the replacement-pointer index type.
package fetch_tlb_pkg;

    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned NUM_ENTRIES_DEF = 8;
    localparam int unsigned VPN_W_DEF       = 20;
    localparam int unsigned PFN_W_DEF       = 3;
    localparam int unsigned LIMIT_W_DEF     = 20;
    localparam int unsigned LINE_OFF_W_DEF  = 5;
    localparam int unsigned PTR_W_DEF       = idx_width(NUM_ENTRIES_DEF);

    typedef logic [PTR_W_DEF-1:0] ptr_t;

    typedef struct packed {
        logic                 valid;
        logic                 present;
        logic [VPN_W_DEF-1:0] vpn;
        logic [PFN_W_DEF-1:0] pfn;
    } tlb_entry_t;

endpackage

// File: rtl/fetch_tlb_match.sv
// Fully-associative VPN compare with lowest-index priority encode.
// Used both for the lookup hit and for fill-in-place detection.
module fetch_tlb_match
    import fetch_tlb_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = NUM_ENTRIES_DEF,
    parameter int unsigned VPN_W       = VPN_W_DEF,
    parameter int unsigned IDX_W       = idx_width(NUM_ENTRIES)
) (
    input  logic [NUM_ENTRIES-1:0]            i_valid,
    input  logic [NUM_ENTRIES-1:0][VPN_W-1:0] i_vpn_tab,
    input  logic [VPN_W-1:0]                  i_vpn,
    output logic                              o_hit,
    output logic [IDX_W-1:0]                  o_idx
);

    // Scan downwards so the lowest matching index is the last one written.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
            if (i_valid[i] && (i_vpn_tab[i] == i_vpn)) begin
                o_hit = 1'b1;
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/fetch_tlb_pipelined.sv
// Registered fetch-stage TLB: fill/invalidate/flush table plus 1-cycle lookup with fault checks.
// Optional hit/miss counters are built when FETCH_TLB_PERF_CNT_EN is defined.
module fetch_tlb_pipelined
    import fetch_tlb_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = NUM_ENTRIES_DEF,
    parameter int unsigned VPN_W       = VPN_W_DEF,
    parameter int unsigned PFN_W       = PFN_W_DEF,
    parameter int unsigned LIMIT_W     = LIMIT_W_DEF,
    parameter int unsigned LINE_OFF_W  = LINE_OFF_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               lu_req,
    input  logic [31:0]        lu_vaddr,
    input  logic [LIMIT_W-1:0] lu_cs_limit,
    input  logic               lu_stall,
    output logic               lu_valid,
    output logic [PFN_W-1:0]   lu_pfn,
    output logic               lu_page_fault,
    output logic               lu_prot_exp,
    input  logic               fill_req,
    input  logic [VPN_W-1:0]   fill_vpn,
    input  logic [PFN_W-1:0]   fill_pfn,
    input  logic               fill_present,
    input  logic               inv_req,
    input  logic [VPN_W-1:0]   inv_vpn,
    input  logic               flush
`ifdef FETCH_TLB_PERF_CNT_EN
    ,
    output logic [31:0]        perf_hits,
    output logic [31:0]        perf_misses
`endif
);

    localparam int unsigned IDX_W     = idx_width(NUM_ENTRIES);
    localparam logic [31:0] LINE_MASK = 32'((64'd1 << LINE_OFF_W) - 64'd1);

    logic [NUM_ENTRIES-1:0]            r_valid, w_valid_d;
    logic [NUM_ENTRIES-1:0]            r_present, w_present_d;
    logic [NUM_ENTRIES-1:0][VPN_W-1:0] r_vpn, w_vpn_d;
    logic [NUM_ENTRIES-1:0][PFN_W-1:0] r_pfn, w_pfn_d;
    logic [IDX_W-1:0]                  r_ptr, w_ptr_d;

    logic               r_lu_valid;
    logic [PFN_W-1:0]   r_lu_pfn;
    logic               r_lu_pf;
    logic               r_lu_pe;

    logic               w_lu_hit;
    logic [IDX_W-1:0]   w_lu_idx;
    logic               w_fill_hit;
    logic [IDX_W-1:0]   w_fill_idx;
    logic [NUM_ENTRIES-1:0] w_inv_vec;
    logic               w_free_any;
    logic [IDX_W-1:0]   w_free_idx;
    logic [IDX_W-1:0]   w_wr_idx;
    logic [31:0]        w_line_end;
    logic [31:0]        w_limit_ext;

    fetch_tlb_match #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .VPN_W       (VPN_W),
        .IDX_W       (IDX_W)
    ) u_lu_match (
        .i_valid   (r_valid & r_present),
        .i_vpn_tab (r_vpn),
        .i_vpn     (lu_vaddr[31 -: VPN_W]),
        .o_hit     (w_lu_hit),
        .o_idx     (w_lu_idx)
    );

    fetch_tlb_match #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .VPN_W       (VPN_W),
        .IDX_W       (IDX_W)
    ) u_fill_match (
        .i_valid   (r_valid),
        .i_vpn_tab (r_vpn),
        .i_vpn     (fill_vpn),
        .o_hit     (w_fill_hit),
        .o_idx     (w_fill_idx)
    );

    always_comb begin
        w_inv_vec  = '0;
        w_free_any = 1'b0;
        w_free_idx = '0;
        for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
            w_inv_vec[i] = (r_vpn[i] == inv_vpn);
            if (!r_valid[i]) begin
                w_free_any = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    // Fill target: in-place match, else lowest free slot, else round-robin pointer.
    always_comb begin
        w_valid_d   = r_valid;
        w_present_d = r_present;
        w_vpn_d     = r_vpn;
        w_pfn_d     = r_pfn;
        w_ptr_d     = r_ptr;
        w_wr_idx    = r_ptr;
        if (w_fill_hit) begin
            w_wr_idx = w_fill_idx;
        end else if (w_free_any) begin
            w_wr_idx = w_free_idx;
        end
        if (flush) begin
            w_valid_d = '0;
            w_ptr_d   = '0;
        end else begin
            if (inv_req) begin
                w_valid_d = r_valid & ~w_inv_vec;
            end
            if (fill_req) begin
                w_valid_d[w_wr_idx]   = 1'b1;
                w_present_d[w_wr_idx] = fill_present;
                w_vpn_d[w_wr_idx]     = fill_vpn;
                w_pfn_d[w_wr_idx]     = fill_pfn;
                if (!w_fill_hit && !w_free_any) begin
                    w_ptr_d = (r_ptr == IDX_W'(NUM_ENTRIES - 1)) ? '0 : r_ptr + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid   <= '0;
            r_present <= '0;
            r_vpn     <= '0;
            r_pfn     <= '0;
            r_ptr     <= '0;
        end else begin
            r_valid   <= w_valid_d;
            r_present <= w_present_d;
            r_vpn     <= w_vpn_d;
            r_pfn     <= w_pfn_d;
            r_ptr     <= w_ptr_d;
        end
    end

    assign w_line_end  = lu_vaddr | LINE_MASK;
    assign w_limit_ext = 32'(lu_cs_limit);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lu_valid <= 1'b0;
            r_lu_pfn   <= '0;
            r_lu_pf    <= 1'b0;
            r_lu_pe    <= 1'b0;
        end else if (!lu_stall) begin
            r_lu_valid <= lu_req;
            r_lu_pfn   <= w_lu_hit ? r_pfn[w_lu_idx] : '0;
            r_lu_pf    <= lu_req & ~w_lu_hit;
            r_lu_pe    <= lu_req & (w_line_end > w_limit_ext);
        end
    end

    assign lu_valid      = r_lu_valid;
    assign lu_pfn        = r_lu_pfn;
    assign lu_page_fault = r_lu_pf;
    assign lu_prot_exp   = r_lu_pe;

`ifdef FETCH_TLB_PERF_CNT_EN
    logic [31:0] r_perf_hits;
    logic [31:0] r_perf_misses;

    // Counters saturate and survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_hits   <= '0;
            r_perf_misses <= '0;
        end else if (lu_req && !lu_stall) begin
            if (w_lu_hit) begin
                if (r_perf_hits != 32'hFFFF_FFFF) begin
                    r_perf_hits <= r_perf_hits + 32'd1;
                end
            end else if (r_perf_misses != 32'hFFFF_FFFF) begin
                r_perf_misses <= r_perf_misses + 32'd1;
            end
        end
    end

    assign perf_hits   = r_perf_hits;
    assign perf_misses = r_perf_misses;
`endif

endmodule

// File: tb/tb_fetch_tlb_pipelined.sv
// Self-checking bench for fetch_tlb_pipelined: directed scenarios plus random traffic
// compared against a table-level reference model.
module tb_fetch_tlb_pipelined;

    localparam int N  = 8;
    localparam int VW = 20;
    localparam int PW = 3;
    localparam int LW = 20;
    localparam int LO = 5;

    logic          clk;
    logic          rst_n;
    logic          lu_req;
    logic [31:0]   lu_vaddr;
    logic [LW-1:0] lu_cs_limit;
    logic          lu_stall;
    logic          lu_valid;
    logic [PW-1:0] lu_pfn;
    logic          lu_page_fault;
    logic          lu_prot_exp;
    logic          fill_req;
    logic [VW-1:0] fill_vpn;
    logic [PW-1:0] fill_pfn;
    logic          fill_present;
    logic          inv_req;
    logic [VW-1:0] inv_vpn;
    logic          flush;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference table and expected registered outputs
    bit          m_valid[N];
    bit          m_present[N];
    bit [VW-1:0] m_vpn[N];
    bit [PW-1:0] m_pfn[N];
    int          m_ptr;
    bit          e_valid;
    bit [PW-1:0] e_pfn;
    bit          e_pf;
    bit          e_pe;

    fetch_tlb_pipelined u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lu_req        (lu_req),
        .lu_vaddr      (lu_vaddr),
        .lu_cs_limit   (lu_cs_limit),
        .lu_stall      (lu_stall),
        .lu_valid      (lu_valid),
        .lu_pfn        (lu_pfn),
        .lu_page_fault (lu_page_fault),
        .lu_prot_exp   (lu_prot_exp),
        .fill_req      (fill_req),
        .fill_vpn      (fill_vpn),
        .fill_pfn      (fill_pfn),
        .fill_present  (fill_present),
        .inv_req       (inv_req),
        .inv_vpn       (inv_vpn),
        .flush         (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_edge();
        int hit;
        int dst;
        if (rst_n !== 1'b1) begin
            for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
            m_ptr = 0;
            {e_valid, e_pfn, e_pf, e_pe} = '0;
            return;
        end
        if (!lu_stall) begin
            hit = -1;
            for (int i = 0; i < N; i++)
                if (hit < 0 && m_valid[i] && m_present[i] && m_vpn[i] == lu_vaddr[31:32-VW])
                    hit = i;
            e_valid = lu_req;
            e_pfn   = (hit >= 0) ? m_pfn[hit] : '0;
            e_pf    = lu_req && (hit < 0);
            e_pe    = lu_req && ((lu_vaddr | ((32'd1 << LO) - 1)) > {{(32-LW){1'b0}}, lu_cs_limit});
        end
        if (flush) begin
            for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
            m_ptr = 0;
            return;
        end
        dst = -1;
        if (fill_req) begin
            for (int i = 0; i < N; i++) if (dst < 0 && m_valid[i] && m_vpn[i] == fill_vpn) dst = i;
            for (int i = 0; i < N; i++) if (dst < 0 && !m_valid[i]) dst = i;
            if (dst < 0) begin
                dst   = m_ptr;
                m_ptr = (m_ptr + 1) % N;
            end
        end
        if (inv_req)
            for (int i = 0; i < N; i++) if (m_vpn[i] == inv_vpn) m_valid[i] = 1'b0;
        if (fill_req) begin
            m_valid[dst]   = 1'b1;
            m_present[dst] = fill_present;
            m_vpn[dst]     = fill_vpn;
            m_pfn[dst]     = fill_pfn;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        lu_req = 0; lu_stall = 0; fill_req = 0; inv_req = 0; flush = 0;
    endtask

    task automatic do_fill(input logic [VW-1:0] v, input logic [PW-1:0] p, input logic pr);
        idle();
        fill_req = 1; fill_vpn = v; fill_pfn = p; fill_present = pr;
        step();
        fill_req = 0;
    endtask

    task automatic do_lookup(input logic [31:0] va, input logic [LW-1:0] lim);
        idle();
        lu_req = 1; lu_vaddr = va; lu_cs_limit = lim;
        step();
        lu_req = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        step(); step();
        n_tests++;
        if ({lu_valid, lu_pfn, lu_page_fault, lu_prot_exp} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 000000",
                     {lu_valid, lu_pfn, lu_page_fault, lu_prot_exp});
        end
        rst_n = 1;
        do_fill(20'h00777, 3'd5, 1'b1);
        do_lookup(32'h0077_7000, 20'hFFFFF);
        n_tests++;
        if ({lu_valid, lu_pfn, lu_page_fault} !== {1'b1, 3'd5, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_prefill_hit: got v=%b pfn=%0d pf=%b required v=1 pfn=5 pf=0",
                     lu_valid, lu_pfn, lu_page_fault);
        end
        // Reset while stalled must still clear everything
        lu_stall = 1; rst_n = 0;
        step();
        n_tests++;
        if ({lu_valid, lu_pfn, lu_page_fault, lu_prot_exp} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_over_stall: got %b required 000000",
                     {lu_valid, lu_pfn, lu_page_fault, lu_prot_exp});
        end
        rst_n = 1;
        do_lookup(32'h0077_7000, 20'hFFFFF);
        n_tests++;
        if ({lu_valid, lu_pfn, lu_page_fault} !== {1'b1, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_clears_table: got v=%b pfn=%0d pf=%b required v=1 pfn=0 pf=1",
                     lu_valid, lu_pfn, lu_page_fault);
        end
    endtask

    task automatic test_basic_hit();
        do_fill(20'h12345, 3'd3, 1'b1);
        do_lookup(32'h1234_5040, 20'hFFFFF);
        // 0x1234505F exceeds the zero-extended limit 0x000FFFFF
        n_tests++;
        if ({lu_valid, lu_pfn, lu_page_fault, lu_prot_exp} !== {1'b1, 3'd3, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL basic_hit: got v=%b pfn=%0d pf=%b pe=%b required v=1 pfn=3 pf=0 pe=1",
                     lu_valid, lu_pfn, lu_page_fault, lu_prot_exp);
        end
        do_fill(20'h00001, 3'd6, 1'b0);
        do_lookup(32'h0000_1000, 20'hFFFFF);
        n_tests++;
        if ({lu_valid, lu_pfn, lu_page_fault} !== {1'b1, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL not_present: got v=%b pfn=%0d pf=%b required v=1 pfn=0 pf=1",
                     lu_valid, lu_pfn, lu_page_fault);
        end
    endtask

    task automatic test_replacement();
        idle();
        rst_n = 0; step(); rst_n = 1;
        for (int i = 0; i < 9; i++) do_fill(VW'(32'h100 + i), PW'(i + 1), 1'b1);
        do_lookup(32'h0010_0000, 20'hFFFFF);
        n_tests++;
        if (lu_page_fault !== 1'b1) begin
            n_fail++;
            $display("FAIL repl_first_evicted: got pf=%b required pf=1", lu_page_fault);
        end
        do_lookup(32'h0010_8000, 20'hFFFFF);
        n_tests++;
        if ({lu_pfn, lu_page_fault} !== {3'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL repl_ninth_hit: got pfn=%0d pf=%b required pfn=1 pf=0",
                     lu_pfn, lu_page_fault);
        end
        // Pointer now at 1: the next fill evicts the second VPN
        do_fill(20'h00109, 3'd7, 1'b1);
        do_lookup(32'h0010_1000, 20'hFFFFF);
        n_tests++;
        if (lu_page_fault !== 1'b1) begin
            n_fail++;
            $display("FAIL repl_ptr_advanced: got pf=%b required pf=1", lu_page_fault);
        end
        do_lookup(32'h0010_2000, 20'hFFFFF);
        n_tests++;
        if ({lu_pfn, lu_page_fault} !== {3'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL repl_third_kept: got pfn=%0d pf=%b required pfn=3 pf=0",
                     lu_pfn, lu_page_fault);
        end
    endtask

    task automatic test_prot_limit();
        do_lookup(32'h0000_00E0, 20'h000F0);
        n_tests++;
        if (lu_prot_exp !== 1'b1) begin
            n_fail++;
            $display("FAIL prot_over_limit: got pe=%b required pe=1", lu_prot_exp);
        end
        do_lookup(32'h0000_00E0, 20'h000FF);
        n_tests++;
        if (lu_prot_exp !== 1'b0) begin
            n_fail++;
            $display("FAIL prot_at_limit: got pe=%b required pe=0", lu_prot_exp);
        end
    endtask

    task automatic test_stall_flush();
        do_fill(20'h0AAAA, 3'd6, 1'b1);
        do_lookup(32'h0AAA_A010, 20'hFFFFF);
        n_tests++;
        if ({lu_valid, lu_pfn, lu_page_fault, lu_prot_exp} !== {1'b1, 3'd6, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL stall_prelookup: got v=%b pfn=%0d pf=%b pe=%b required 1/6/0/1",
                     lu_valid, lu_pfn, lu_page_fault, lu_prot_exp);
        end
        for (int k = 0; k < 3; k++) begin
            idle();
            lu_stall = 1; lu_req = 1'($urandom); lu_vaddr = $urandom; lu_cs_limit = '0;
            flush = (k == 1);
            step();
            n_tests++;
            if ({lu_valid, lu_pfn, lu_page_fault, lu_prot_exp} !== {1'b1, 3'd6, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got v=%b pfn=%0d pf=%b pe=%b required 1/6/0/1",
                         k, lu_valid, lu_pfn, lu_page_fault, lu_prot_exp);
            end
        end
        do_lookup(32'h0AAA_A010, 20'hFFFFF);
        n_tests++;
        if ({lu_pfn, lu_page_fault} !== {3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL flush_in_stall: got pfn=%0d pf=%b required pfn=0 pf=1",
                     lu_pfn, lu_page_fault);
        end
    endtask

    task automatic test_coincident();
        idle();
        fill_req = 1; fill_vpn = 20'h0BBBB; fill_pfn = 3'd2; fill_present = 1;
        inv_req = 1; inv_vpn = 20'h0BBBB;
        step();
        do_lookup(32'h0BBB_B000, 20'hFFFFF);
        n_tests++;
        if ({lu_pfn, lu_page_fault} !== {3'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL fill_beats_inv: got pfn=%0d pf=%b required pfn=2 pf=0",
                     lu_pfn, lu_page_fault);
        end
        idle();
        fill_req = 1; fill_vpn = 20'h0DDDD; fill_pfn = 3'd4; fill_present = 1;
        inv_req = 1; inv_vpn = 20'h0BBBB;
        step();
        do_lookup(32'h0DDD_D000, 20'hFFFFF);
        n_tests++;
        if ({lu_pfn, lu_page_fault} !== {3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL fill_inv_diff_fill: got pfn=%0d pf=%b required pfn=4 pf=0",
                     lu_pfn, lu_page_fault);
        end
        do_lookup(32'h0BBB_B000, 20'hFFFFF);
        n_tests++;
        if (lu_page_fault !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_inv_diff_inv: got pf=%b required pf=1", lu_page_fault);
        end
        idle();
        flush = 1;
        fill_req = 1; fill_vpn = 20'h0CCCC; fill_pfn = 3'd5; fill_present = 1;
        step();
        do_lookup(32'h0CCC_C000, 20'hFFFFF);
        n_tests++;
        if (lu_page_fault !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_beats_fill: got pf=%b required pf=1", lu_page_fault);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            rst_n        = ($urandom_range(0, 99) != 0);
            lu_req       = ($urandom_range(0, 9) < 7);
            lu_vaddr     = {VW'($urandom_range(0, 11)), 12'($urandom)};
            lu_cs_limit  = LW'($urandom_range(0, 'hFFFF));
            lu_stall     = ($urandom_range(0, 3) == 0);
            fill_req     = ($urandom_range(0, 9) < 4);
            fill_vpn     = VW'($urandom_range(0, 11));
            fill_pfn     = PW'($urandom);
            fill_present = ($urandom_range(0, 4) != 0);
            inv_req      = ($urandom_range(0, 19) < 3);
            inv_vpn      = VW'($urandom_range(0, 11));
            flush        = ($urandom_range(0, 39) == 0);
            step();
            n_tests++;
            if ({lu_valid, lu_pfn, lu_page_fault, lu_prot_exp} !== {e_valid, e_pfn, e_pf, e_pe}) begin
                n_fail++;
                $display("FAIL random[%0d]: got v=%b pfn=%0d pf=%b pe=%b required v=%b pfn=%0d pf=%b pe=%b",
                         c, lu_valid, lu_pfn, lu_page_fault, lu_prot_exp,
                         e_valid, e_pfn, e_pf, e_pe);
            end
        end
        rst_n = 1;
        idle();
    endtask

    initial begin
        rst_n = 0;
        lu_vaddr = '0; lu_cs_limit = '0;
        fill_vpn = '0; fill_pfn = '0; fill_present = 0; inv_vpn = '0;
        idle();
        test_reset();
        test_basic_hit();
        test_replacement();
        test_prot_limit();
        test_stall_flush();
        test_coincident();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
